// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file placed between decode (reads) and writeback
//   (write). It has one synchronous write port and two independent
//   combinational read ports. A sequenced bulk-clear engine zeroes one entry
//   per clock and reports progress on `busy`.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a write in the current cycle is forwarded to any read port
//                 whose address matches the write address (write-first).
//     undefined : read ports show only the stored contents.
//
// Parameters
//   DATA_W  bits per entry
//   DATA_D  number of entries (2 .. 2**ADDR_W)
//   ADDR_W  address width
//
// Ports
//   clk      in   rising-edge clock
//   reset_   in   asynchronous active-low reset (array, FSM and counter to 0)
//   we_      in   write enable, active-low
//   waddr    in   write address
//   d_in     in   write data
//   raddr_a  in   read port A address
//   d_out_a  out  read port A data (0 while busy or when out of range)
//   raddr_b  in   read port B address
//   d_out_b  out  read port B data (0 while busy or when out of range)
//   clr_     in   bulk-clear request, active-low, sampled on the clock edge
//   busy     out  high while the bulk clear is running
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int DATA_D = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              we_,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] d_in,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] d_out_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] d_out_b,
   input  logic              clr_,
   output logic              busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   // One extra bit so a depth of exactly 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(DATA_D);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DATA_D - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DATA_D];

   logic              clr_start;
   logic              clr_done;
   logic              wr_fire;

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} < DEPTH);
   endfunction

   // A clear request in IDLE wins over a write presented on the same edge.
   assign clr_start = (state == IDLE) && !clr_;
   assign clr_done  = (state == CLEAR) && (cnt == LAST);
   assign wr_fire   = (state == IDLE) && clr_ && !we_ && in_range(waddr);
   assign busy      = (state == CLEAR);

   // FSM state register
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!clr_)   state_nxt = CLEAR;
         CLEAR: if (clr_done) state_nxt = IDLE;
      endcase
   end

   // Clear counter: loaded on request, walks 0..DATA_D-1, never wraps.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)        cnt <= '0;
      else if (clr_start) cnt <= '0;
      else if (busy)      cnt <= clr_done ? '0 : cnt + 1'b1;
   end

   // Storage array
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < DATA_D; i++) mem[i] <= '0;
      end else if (busy) begin
         mem[cnt] <= '0;
      end else if (wr_fire) begin
         mem[waddr] <= d_in;
      end
   end

   // Read ports: busy forcing has precedence over forwarding and storage.
   always_comb begin
      d_out_a = '0;
      d_out_b = '0;
      if (!busy && in_range(raddr_a)) d_out_a = mem[raddr_a];
      if (!busy && in_range(raddr_b)) d_out_b = mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (raddr_a == waddr)) d_out_a = d_in;
      if (wr_fire && (raddr_b == waddr)) d_out_b = d_in;
`endif
   end

endmodule
